// File: rtl/sv32_table_walk.sv
// sv32_table_walk: Sv32 two-level hardware page-table walker.
// A request reads the level-1 PTE at satp.PPN, optionally the level-0 PTE,
// and returns one leaf PTE whose PPN concatenated with the page offset is the
// physical address. Structural faults return an all-zero PTE.
// Build option: define SV32_WALK_TLB_EN to add a TLB_ENTRIES-deep
// fully-associative cache of completed (non-zero) translations.
module sv32_table_walk #(
    parameter int TLB_ENTRIES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] address,
    input  logic [31:0] satp,
    input  logic        walk_valid,
    output logic        walk_ready,
    output logic [31:0] pte,
    input  logic        tlb_flush,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [33:0] mem_addr,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LVL1 = 2'd1;
    localparam logic [1:0] ST_LVL0 = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // V=0, or writable without readable: reserved encoding
    function automatic logic pte_bad(input logic [31:0] p);
        return (p[0] == 1'b0) || (p[2] && !p[1]);
    endfunction

    // R or X set: the entry maps a page rather than pointing to a table
    function automatic logic pte_leaf(input logic [31:0] p);
        return p[1] || p[3];
    endfunction

    logic [1:0]  state_r;
    logic [19:0] vpn_r;
    logic        walk_ready_r;
    logic [31:0] pte_r;
    logic        mem_valid_r;
    logic [33:0] mem_addr_r;
    logic        from_walk_r;

    logic        descend_s;
    logic [31:0] result_s;
    logic        tlb_hit_s;
    logic [31:0] tlb_pte_s;

    // Evaluate the PTE returned by the current read
    always_comb begin
        descend_s = 1'b0;
        result_s  = 32'd0;
        case (state_r)
            ST_LVL1: begin
                if (pte_bad(mem_rdata)) begin
                    result_s = 32'd0;
                end else if (pte_leaf(mem_rdata)) begin
                    // superpage: PPN[0] must be zero, then VPN0 fills its slot
                    if (mem_rdata[19:10] != 10'd0) begin
                        result_s = 32'd0;
                    end else begin
                        result_s = {mem_rdata[31:20], vpn_r[9:0], mem_rdata[9:0]};
                    end
                end else begin
                    descend_s = 1'b1;
                end
            end
            ST_LVL0: begin
                if (pte_bad(mem_rdata) || !pte_leaf(mem_rdata)) begin
                    result_s = 32'd0;
                end else begin
                    result_s = mem_rdata;
                end
            end
            default: begin
                descend_s = 1'b0;
                result_s  = 32'd0;
            end
        endcase
    end

    // Walk sequencing: accept request, issue PTE reads, register the result
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            vpn_r        <= 20'd0;
            walk_ready_r <= 1'b0;
            pte_r        <= 32'd0;
            mem_valid_r  <= 1'b0;
            mem_addr_r   <= 34'd0;
            from_walk_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    walk_ready_r <= 1'b0;
                    if (walk_valid && tlb_hit_s) begin
                        vpn_r        <= address[31:12];
                        pte_r        <= tlb_pte_s;
                        walk_ready_r <= 1'b1;
                        from_walk_r  <= 1'b0;
                        state_r      <= ST_DONE;
                    end else if (walk_valid) begin
                        vpn_r       <= address[31:12];
                        mem_addr_r  <= {satp[21:0], address[31:22], 2'b00};
                        mem_valid_r <= 1'b1;
                        from_walk_r <= 1'b1;
                        state_r     <= ST_LVL1;
                    end
                end
                ST_LVL1, ST_LVL0: begin
                    if (mem_ready) begin
                        if (descend_s) begin
                            mem_addr_r <= {mem_rdata[31:10], vpn_r[9:0], 2'b00};
                            state_r    <= ST_LVL0;
                        end else begin
                            pte_r        <= result_s;
                            walk_ready_r <= 1'b1;
                            mem_valid_r  <= 1'b0;
                            state_r      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    walk_ready_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    walk_ready_r <= 1'b0;
                    mem_valid_r  <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SV32_WALK_TLB_EN
    localparam int TLB_IDXW = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

    logic [TLB_ENTRIES-1:0] tlb_valid_r;
    logic [19:0]            tlb_tag_r  [TLB_ENTRIES];
    logic [31:0]            tlb_data_r [TLB_ENTRIES];
    logic [TLB_IDXW-1:0]    tlb_victim_r;
    logic [31:0]            tlb_satp_r;
    logic                   tlb_clear_s;
    logic                   tlb_fill_s;
    logic [11:0]            unused_s;

    assign tlb_clear_s = tlb_flush || ((|tlb_valid_r) && (satp != tlb_satp_r));
    assign tlb_fill_s  = (state_r == ST_DONE) && from_walk_r && (pte_r != 32'd0);
    assign unused_s    = address[11:0];

    // Fully-associative lookup on VPN; a pending invalidate suppresses hits
    always_comb begin
        tlb_hit_s = 1'b0;
        tlb_pte_s = 32'd0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (tlb_valid_r[i] && (tlb_tag_r[i] == address[31:12])) begin
                tlb_hit_s = 1'b1;
                tlb_pte_s = tlb_data_r[i];
            end else begin
                tlb_hit_s = tlb_hit_s;
            end
        end
        if (tlb_clear_s) begin
            tlb_hit_s = 1'b0;
        end else begin
            tlb_hit_s = tlb_hit_s;
        end
    end

    // Invalidate (wins over a same-cycle fill) or fill the round-robin victim
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tlb_valid_r  <= '0;
            tlb_victim_r <= '0;
            tlb_satp_r   <= 32'd0;
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                tlb_tag_r[i]  <= 20'd0;
                tlb_data_r[i] <= 32'd0;
            end
        end else if (tlb_clear_s) begin
            tlb_valid_r <= '0;
        end else if (tlb_fill_s) begin
            tlb_valid_r[tlb_victim_r] <= 1'b1;
            tlb_tag_r[tlb_victim_r]   <= vpn_r;
            tlb_data_r[tlb_victim_r]  <= pte_r;
            tlb_satp_r                <= satp;
            if (tlb_victim_r == TLB_IDXW'(TLB_ENTRIES - 1)) begin
                tlb_victim_r <= '0;
            end else begin
                tlb_victim_r <= tlb_victim_r + TLB_IDXW'(1);
            end
        end
    end
`else
    localparam int UNUSED_TLB_ENTRIES = TLB_ENTRIES;
    logic [23:0] unused_s;

    assign tlb_hit_s = 1'b0;
    assign tlb_pte_s = 32'd0;
    assign unused_s  = {tlb_flush, from_walk_r, satp[31:22], address[11:0]};
`endif

    assign walk_ready = walk_ready_r;
    assign pte        = pte_r;
    assign mem_valid  = mem_valid_r;
    assign mem_addr   = mem_addr_r;

endmodule

// File: tb/tb_sv32_table_walk.sv
// tb_sv32_table_walk: directed and randomized bench for sv32_table_walk.
// A sparse word memory answers PTE reads with a programmable number of wait
// cycles; expected results come from a behavioural Sv32 walk over that memory.
module tb_sv32_table_walk;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] address;
    logic [31:0] satp;
    logic        walk_valid;
    logic        walk_ready;
    logic [31:0] pte;
    logic        tlb_flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [33:0] mem_addr;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    int   cfg_wait = 0;
    int   wait_left = 0;
    logic force_ready = 1'b0;
    int   mem_gen = 0;
    logic [31:0] mem_m [logic [33:0]];

    sv32_table_walk #(.TLB_ENTRIES(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .address    (address),
        .satp       (satp),
        .walk_valid (walk_valid),
        .walk_ready (walk_ready),
        .pte        (pte),
        .tlb_flush  (tlb_flush),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory wait-state counter: reload per request, count down while stalled
    always @(posedge clk) begin
        if (!mem_valid || mem_ready) wait_left <= cfg_wait;
        else wait_left <= wait_left - 1;
    end

    // Memory response
    always @(mem_valid, wait_left, force_ready)
        mem_ready = force_ready || (mem_valid && (wait_left == 0));

    // Memory read data
    always @(mem_addr, mem_gen)
        mem_rdata = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_mem(input logic [33:0] a, input logic [31:0] d);
        mem_m[a] = d;
        mem_gen++;
    endtask

    task automatic clear_mem();
        mem_m.delete();
        mem_gen++;
    endtask

    function automatic logic [31:0] rd(input logic [33:0] a);
        return mem_m.exists(a) ? mem_m[a] : 32'd0;
    endfunction

    // Reference Sv32 walk: PTE address = PPN*4096 + VPN*4
    function automatic void ref_walk(input logic [31:0] va, input logic [31:0] sp,
                                     output logic [31:0] r, output int nrd,
                                     output logic [33:0] a1, output logic [33:0] a2);
        logic [31:0] p1, p0;
        int unsigned vpn1, vpn0;
        vpn1 = va >> 22;
        vpn0 = (va >> 12) % 1024;
        a1 = 34'(sp[21:0]) * 34'd4096 + 34'(vpn1) * 34'd4;
        a2 = 34'd0;
        p1 = rd(a1);
        nrd = 1;
        r = 32'd0;
        if (!p1[0] || (p1[2] && !p1[1])) begin
            r = 32'd0;
        end else if (p1[1] || p1[3]) begin
            if (((p1 >> 10) % 1024) != 0) r = 32'd0;
            else r = (p1 & 32'hFFF0_03FF) | (vpn0 << 10);
        end else begin
            a2 = 34'(p1 >> 10) * 34'd4096 + 34'(vpn0) * 34'd4;
            p0 = rd(a2);
            nrd = 2;
            if (!p0[0] || (p0[2] && !p0[1]) || !(p0[1] || p0[3])) r = 32'd0;
            else r = p0;
        end
    endfunction

    task automatic flush_tlb();
        tlb_flush = 1'b1;
        @(posedge clk); #1;
        tlb_flush = 1'b0;
    endtask

    // One request; checks read addresses, address/valid hold while stalled,
    // latency, result and result hold after the pulse
    task automatic do_walk(input logic [31:0] va, input logic [31:0] sp,
                           input logic [31:0] exp_pte, input int exp_reads, input int exp_lat,
                           input logic [33:0] ea1, input logic [33:0] ea2);
        int n;
        int reads;
        logic waiting;
        logic [33:0] prev_addr;
        address = va;
        satp = sp;
        walk_valid = 1'b1;
        @(posedge clk); #1;
        walk_valid = 1'b0;
        address = $urandom;
        n = 1;
        reads = 0;
        waiting = 1'b0;
        prev_addr = 34'd0;
        while (!walk_ready && n < 60) begin
            if (waiting) begin
                check("hold_valid", 64'(mem_valid), 64'(1'b1));
                check("hold_addr", 64'(mem_addr), 64'(prev_addr));
            end
            if (mem_valid && mem_ready) begin
                check("rd_addr", 64'(mem_addr), 64'((reads == 0) ? ea1 : ea2));
                reads++;
                waiting = 1'b0;
            end else begin
                waiting = mem_valid;
                prev_addr = mem_addr;
            end
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(exp_lat));
        check("reads", 64'(reads), 64'(exp_reads));
        check("pte", 64'(pte), 64'(exp_pte));
        @(posedge clk); #1;
        check("ready_pulse", 64'(walk_ready), 64'(1'b0));
        check("pte_held", 64'(pte), 64'(exp_pte));
    endtask

    task automatic load_test1();
        clear_mem();
        set_mem(34'h0_0010_0004, 32'h0004_0401);
        set_mem(34'h0_0010_1004, 32'h2000_00CF);
    endtask

    initial begin
        logic [31:0] va, sp, l1, l0, r, ep;
        logic [33:0] a1, a2, ea1, ea2;
        int nrd;

        resetn = 1'b0;
        walk_valid = 1'b0;
        tlb_flush = 1'b0;
        address = 32'd0;
        satp = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(walk_ready), 64'(1'b0));
        check("rst_pte", 64'(pte), 64'd0);
        check("rst_mvalid", 64'(mem_valid), 64'(1'b0));
        check("rst_maddr", 64'(mem_addr), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // 4 KiB page, zero-wait
        load_test1();
        flush_tlb();
        do_walk(32'h0040_1234, 32'h8000_0100, 32'h2000_00CF, 2, 3, 34'h0_0010_0004, 34'h0_0010_1004);
        // aligned superpage
        set_mem(34'h0_0010_0004, 32'h2000_00CF);
        flush_tlb();
        do_walk(32'h0040_1234, 32'h8000_0100, 32'h2000_04CF, 1, 2, 34'h0_0010_0004, 34'h0);
        // misaligned superpage
        set_mem(34'h0_0010_0004, 32'h2000_04CF);
        flush_tlb();
        do_walk(32'h0040_1234, 32'h8000_0100, 32'h0, 1, 2, 34'h0_0010_0004, 34'h0);
        // invalid level-1 entry
        set_mem(34'h0_0010_0004, 32'h0000_0004);
        flush_tlb();
        do_walk(32'h0040_1234, 32'h8000_0100, 32'h0, 1, 2, 34'h0_0010_0004, 34'h0);
        // pointer at level 0
        load_test1();
        set_mem(34'h0_0010_1004, 32'h0004_0401);
        flush_tlb();
        do_walk(32'h0040_1234, 32'h8000_0100, 32'h0, 2, 3, 34'h0_0010_0004, 34'h0_0010_1004);
        // three wait cycles per read
        load_test1();
        cfg_wait = 3;
        flush_tlb();
        do_walk(32'h0040_1234, 32'h8000_0100, 32'h2000_00CF, 2, 9, 34'h0_0010_0004, 34'h0_0010_1004);
        cfg_wait = 0;

`ifdef SV32_WALK_TLB_EN
        flush_tlb();
        do_walk(32'h0040_1234, 32'h8000_0100, 32'h2000_00CF, 2, 3, 34'h0_0010_0004, 34'h0_0010_1004);
        do_walk(32'h0040_1234, 32'h8000_0100, 32'h2000_00CF, 0, 1, 34'h0_0010_0004, 34'h0_0010_1004);
        flush_tlb();
        do_walk(32'h0040_1234, 32'h8000_0100, 32'h2000_00CF, 2, 3, 34'h0_0010_0004, 34'h0_0010_1004);
`endif

        // reset while waiting on the level-0 read, then a stray mem_ready
        cfg_wait = 3;
        flush_tlb();
        address = 32'h0040_1234;
        satp = 32'h8000_0100;
        walk_valid = 1'b1;
        @(posedge clk); #1;
        walk_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_valid", 64'(mem_valid), 64'(1'b1));
        check("mid_addr", 64'(mem_addr), 64'h0_0010_1004);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("mrst_mvalid", 64'(mem_valid), 64'(1'b0));
        check("mrst_ready", 64'(walk_ready), 64'(1'b0));
        check("mrst_pte", 64'(pte), 64'd0);
        resetn = 1'b1;
        force_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("late_ready", 64'(walk_ready), 64'(1'b0));
            check("late_mvalid", 64'(mem_valid), 64'(1'b0));
        end
        force_ready = 1'b0;

        // randomized page tables
        for (int it = 0; it < 150; it++) begin
            sp = $urandom;
            va = $urandom;
            cfg_wait = $urandom_range(0, 2);
            clear_mem();
            a1 = 34'(sp[21:0]) * 34'd4096 + 34'(va[31:22]) * 34'd4;
            r = $urandom;
            case ($urandom_range(0, 5))
                0: l1 = r & 32'hFFFF_FFFE;
                1: l1 = (r & 32'hFFFF_FFF0) | 32'h5;
                2: l1 = (r & 32'hFFF0_03FF) | 32'h3;
                3: l1 = (r & 32'hFFF0_03FF) | 32'h9 | (32'($urandom_range(1, 1023)) << 10);
                default: l1 = (r & 32'hFFFF_FFF1) | 32'h1;
            endcase
            set_mem(a1, l1);
            if (!l1[1] && !l1[3]) begin
                a2 = 34'(l1[31:10]) * 34'd4096 + 34'(va[21:12]) * 34'd4;
                r = $urandom;
                case ($urandom_range(0, 4))
                    0: l0 = r & 32'hFFFF_FFFE;
                    1: l0 = (r & 32'hFFFF_FFF0) | 32'h5;
                    2: l0 = (r & 32'hFFFF_FFF1) | 32'h1;
                    3: l0 = r | 32'h3;
                    default: l0 = r | 32'h9;
                endcase
                set_mem(a2, l0);
            end
            ref_walk(va, sp, ep, nrd, ea1, ea2);
            flush_tlb();
            do_walk(va, sp, ep, nrd, nrd * (cfg_wait + 1) + 1, ea1, ea2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
